// File: rtl/tx_pu_ctrl_if.sv
// tx_pu_ctrl_if: power-up request and TX front-end enable/status bundle
interface tx_pu_ctrl_if;
    logic pu_tx;
    logic rdy_tx;
    logic en_bias;
    logic en_lo;
    logic en_pa;
    logic busy;
    modport master (output pu_tx, input rdy_tx, en_bias, en_lo, en_pa, busy);
    modport slave (input pu_tx, output rdy_tx, en_bias, en_lo, en_pa, busy);
endinterface

// File: rtl/tx_pu_ctrl.sv
// tx_pu_ctrl: timed TX power-up sequencer (bias -> LO -> PA) with ordered ramp-down
module tx_pu_ctrl #(
    parameter int T_BIAS = 16,
    parameter int T_LO   = 32,
    parameter int T_PA   = 8,
    parameter int T_OFF  = 4,
    parameter int CW     = 8
) (
    input  logic clk,
    input  logic rst_n,
    tx_pu_ctrl_if.slave bus
);
    typedef enum logic [2:0] {OFF, BIAS, LO, PA, READY, RAMPDN} state_t;
    localparam logic [CW-1:0] BIAS_END = CW'(T_BIAS - 1);
    localparam logic [CW-1:0] LO_END   = CW'(T_LO - 1);
    localparam logic [CW-1:0] PA_END   = CW'(T_PA - 1);
    localparam logic [CW-1:0] OFF_END  = CW'(T_OFF - 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic pu_m, pu_s;
    // two-flop synchronizer for the asynchronous request level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pu_m <= 1'b0;
            pu_s <= 1'b0;
        end else begin
            pu_m <= bus.pu_tx;
            pu_s <= pu_m;
        end
    end
    // next state and dwell counter; a dropped request beats counter expiry
    always_comb begin
        state_n = state;
        case (state)
            OFF:     state_n = pu_s ? BIAS : OFF;
            BIAS:    state_n = !pu_s ? RAMPDN : (cnt == BIAS_END) ? LO : BIAS;
            LO:      state_n = !pu_s ? RAMPDN : (cnt == LO_END) ? PA : LO;
            PA:      state_n = !pu_s ? RAMPDN : (cnt == PA_END) ? READY : PA;
            READY:   state_n = !pu_s ? RAMPDN : READY;
            RAMPDN:  state_n = (cnt == OFF_END) ? OFF : RAMPDN;
            default: state_n = OFF;
        endcase
        cnt_n = (state_n != state) ? '0 :
                (state inside {BIAS, LO, PA, RAMPDN}) ? cnt + CW'(1) : cnt;
    end
    // state, counter and registered enable decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OFF;
            cnt         <= '0;
            bus.en_bias <= 1'b0;
            bus.en_lo   <= 1'b0;
            bus.en_pa   <= 1'b0;
            bus.rdy_tx  <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bus.en_bias <= state_n != OFF;
            bus.en_lo   <= state_n inside {LO, PA, READY, RAMPDN};
            bus.en_pa   <= state_n inside {PA, READY};
            bus.rdy_tx  <= state_n == READY;
            bus.busy    <= state_n inside {BIAS, LO, PA, RAMPDN};
        end
    end
endmodule

// File: tb/tb_tx_pu_ctrl.sv
// tb_tx_pu_ctrl: directed edge-by-edge checks of the TX power-up sequencer
module tb_tx_pu_ctrl;
    // output vector order: {rdy_tx, en_bias, en_lo, en_pa, busy}
    localparam logic [4:0] V_OFF   = 5'b00000;
    localparam logic [4:0] V_BIAS  = 5'b01001;
    localparam logic [4:0] V_LO    = 5'b01101;
    localparam logic [4:0] V_PA    = 5'b01111;
    localparam logic [4:0] V_READY = 5'b11110;
    localparam logic [4:0] V_RAMP  = 5'b01101;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    tx_pu_ctrl_if bus ();
    tx_pu_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // guard against a stuck run
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    task automatic test_reset;
        logic [4:0] exp, got;
        rst_n = 1'b0;
        bus.pu_tx = 1'b1;
        #1;
        got = {bus.rdy_tx, bus.en_bias, bus.en_lo, bus.en_pa, bus.busy};
        total++;
        if (got !== V_OFF) begin bad++; $display("FAIL reset_initial got=%b exp=%b", got, V_OFF); end
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            got = {bus.rdy_tx, bus.en_bias, bus.en_lo, bus.en_pa, bus.busy};
            total++;
            if (got !== V_OFF) begin bad++; $display("FAIL reset_hold cyc %0d got=%b exp=%b", n, got, V_OFF); end
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            exp = n < 3 ? V_OFF : n < 19 ? V_BIAS : n < 51 ? V_LO : n < 59 ? V_PA : V_READY;
            got = {bus.rdy_tx, bus.en_bias, bus.en_lo, bus.en_pa, bus.busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL reset_release edge %0d got=%b exp=%b", n, got, exp); end
        end
    endtask
    task automatic test_power_down;
        logic [4:0] exp, got;
        int busy_cyc = 0;
        bus.pu_tx = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk); #1;
            exp = n < 3 ? V_READY : n < 7 ? V_RAMP : V_OFF;
            got = {bus.rdy_tx, bus.en_bias, bus.en_lo, bus.en_pa, bus.busy};
            busy_cyc += int'(bus.busy);
            total++;
            if (got !== exp) begin bad++; $display("FAIL power_down edge %0d got=%b exp=%b", n, got, exp); end
        end
        total++;
        if (busy_cyc !== 4) begin bad++; $display("FAIL power_down_busy_len got=%0d exp=4", busy_cyc); end
    endtask
    task automatic test_power_up;
        logic [4:0] exp, got;
        bus.pu_tx = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            exp = n < 3 ? V_OFF : n < 19 ? V_BIAS : n < 51 ? V_LO : n < 59 ? V_PA : V_READY;
            got = {bus.rdy_tx, bus.en_bias, bus.en_lo, bus.en_pa, bus.busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL power_up edge %0d got=%b exp=%b", n, got, exp); end
        end
    endtask
    task automatic test_abort_lo;
        logic [4:0] exp, got;
        bus.pu_tx = 1'b1;
        for (int n = 1; n <= 29; n++) begin
            @(posedge clk); #1;
            exp = n < 3 ? V_OFF : n < 19 ? V_BIAS : V_LO;
            got = {bus.rdy_tx, bus.en_bias, bus.en_lo, bus.en_pa, bus.busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL abort_rampup edge %0d got=%b exp=%b", n, got, exp); end
        end
        bus.pu_tx = 1'b0;
        for (int m = 1; m <= 9; m++) begin
            @(posedge clk); #1;
            exp = m < 3 ? V_LO : m < 7 ? V_RAMP : V_OFF;
            got = {bus.rdy_tx, bus.en_bias, bus.en_lo, bus.en_pa, bus.busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL abort_lo edge %0d got=%b exp=%b", m, got, exp); end
        end
    endtask
    task automatic test_rerequest;
        logic [4:0] exp, got;
        bus.pu_tx = 1'b0;
        for (int n = 1; n <= 66; n++) begin
            @(posedge clk); #1;
            if (n == 4) bus.pu_tx = 1'b1;
            exp = n < 3 ? V_READY : n < 7 ? V_RAMP : n < 8 ? V_OFF : n < 24 ? V_BIAS :
                  n < 56 ? V_LO : n < 64 ? V_PA : V_READY;
            got = {bus.rdy_tx, bus.en_bias, bus.en_lo, bus.en_pa, bus.busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL rerequest edge %0d got=%b exp=%b", n, got, exp); end
        end
    endtask
    task automatic test_async_reset;
        logic [4:0] exp, got;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        got = {bus.rdy_tx, bus.en_bias, bus.en_lo, bus.en_pa, bus.busy};
        total++;
        if (got !== V_OFF) begin bad++; $display("FAIL async_reset_drop got=%b exp=%b", got, V_OFF); end
        @(posedge clk); #4;
        rst_n = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            exp = n < 3 ? V_OFF : n < 19 ? V_BIAS : n < 51 ? V_LO : n < 59 ? V_PA : V_READY;
            got = {bus.rdy_tx, bus.en_bias, bus.en_lo, bus.en_pa, bus.busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL async_reset_restart edge %0d got=%b exp=%b", n, got, exp); end
        end
    endtask
    task automatic test_short_pulse;
        logic [4:0] exp, got;
        bus.pu_tx = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            bus.pu_tx = 1'b0;
            exp = n < 3 ? V_OFF : n < 4 ? V_BIAS : n < 8 ? V_RAMP : V_OFF;
            got = {bus.rdy_tx, bus.en_bias, bus.en_lo, bus.en_pa, bus.busy};
            total++;
            if (got !== exp) begin bad++; $display("FAIL short_pulse edge %0d got=%b exp=%b", n, got, exp); end
        end
    endtask
    initial begin
        bus.pu_tx = 1'b0;
        test_reset();
        test_power_down();
        test_power_up();
        test_rerequest();
        test_async_reset();
        test_power_down();
        test_abort_lo();
        test_short_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
